// File: rtl/dcache_ctrl_pkg.sv
// Shared definitions for the direct-mapped write-through data cache.
//   DCACHE_LINES : default number of one-word lines
//   CNT_MAX      : saturation value of the hit/miss counters
//   state_t      : controller state encoding
package dcache_ctrl_pkg;

    localparam int unsigned DCACHE_LINES = 16;
    localparam logic [15:0] CNT_MAX      = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REFILL = 2'd1,
        WRITE  = 2'd2
    } state_t;

endpackage

// File: rtl/dcache_array.sv
// Line storage for the data cache: valid bit, tag and 32-bit word per line.
//   clk, rst_n     : clock, asynchronous active-low reset (clears valid bits)
//   flush          : clear every valid bit at the next edge
//   we/widx/wtag/wdata : single write port, sets the line valid
//   ridx -> rvalid/rtag/rdata : combinational read port
module dcache_array #(
    parameter  int unsigned LINES = 16,
    parameter  int unsigned TAG_W = 6,
    localparam int unsigned IDX_W = $clog2(LINES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             we,
    input  logic [IDX_W-1:0] widx,
    input  logic [TAG_W-1:0] wtag,
    input  logic [31:0]      wdata,
    input  logic [IDX_W-1:0] ridx,
    output logic             rvalid,
    output logic [TAG_W-1:0] rtag,
    output logic [31:0]      rdata
);

    logic [LINES-1:0] valid;
    logic [TAG_W-1:0] tag_mem  [LINES];
    logic [31:0]      data_mem [LINES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
        end else if (flush) begin
            valid <= '0;
        end else if (we) begin
            valid[widx] <= 1'b1;
        end
    end

    // Tag/data need no reset: they are only observed through a valid bit.
    always_ff @(posedge clk) begin
        if (we) begin
            tag_mem[widx]  <= wtag;
            data_mem[widx] <= wdata;
        end
    end

    assign rvalid = valid[ridx];
    assign rtag   = tag_mem[ridx];
    assign rdata  = data_mem[ridx];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, one-word-line, write-through / no-write-allocate data cache
// controller sitting between the core and a backing memory.
//   i_clk, i_rst_n              : clock, asynchronous active-low reset
//   i_req/i_we/i_addr/i_data    : core request (held until o_ready)
//   i_flush                     : invalidate all lines (honoured in IDLE only)
//   o_data/o_ready              : load data, access-complete strobe
//   o_mem_req/o_mem_we/o_mem_addr/o_mem_data : backing-memory request
//   i_mem_data/i_mem_ack        : memory read data, completion strobe
//   o_hits/o_misses             : saturating load hit/miss counters
module dcache_ctrl
    import dcache_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 12,
    parameter int unsigned LINES = DCACHE_LINES
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_req,
    input  logic             i_we,
    input  logic [WIDTH-1:0] i_addr,
    input  logic [31:0]      i_data,
    input  logic             i_flush,
    output logic [31:0]      o_data,
    output logic             o_ready,
    output logic             o_mem_req,
    output logic             o_mem_we,
    output logic [WIDTH-1:0] o_mem_addr,
    output logic [31:0]      o_mem_data,
    input  logic [31:0]      i_mem_data,
    input  logic             i_mem_ack,
    output logic [15:0]      o_hits,
    output logic [15:0]      o_misses
);

    localparam int unsigned IDX_W = $clog2(LINES);
    localparam int unsigned TAG_W = WIDTH - IDX_W - 2;

    state_t           state;
    logic [WIDTH-1:0] cur_addr;
    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] req_tag;
    logic             line_valid;
    logic [TAG_W-1:0] line_tag;
    logic [31:0]      line_data;
    logic             line_hit;
    logic             load_hit;
    logic             refill_done;
    logic             write_done;
    logic             arr_we;
    logic [31:0]      arr_wdata;

    // Outside IDLE the registered memory address doubles as the captured
    // request address: it holds the same index and tag bits.
    assign cur_addr    = (state == IDLE) ? i_addr : o_mem_addr;
    assign idx         = cur_addr[IDX_W+1:2];
    assign req_tag     = cur_addr[WIDTH-1:IDX_W+2];
    assign line_hit    = line_valid && (line_tag == req_tag);

    assign load_hit    = (state == IDLE) && !i_flush && i_req && !i_we && line_hit;
    assign refill_done = (state == REFILL) && i_mem_ack;
    assign write_done  = (state == WRITE) && i_mem_ack;

    assign o_ready     = load_hit || refill_done || write_done;

    always_comb begin
        o_data = '0;
        if (load_hit) begin
            o_data = line_data;
        end else if (refill_done) begin
            o_data = i_mem_data;
        end
    end

    // Stores only touch a line that already holds the same address.
    assign arr_we    = refill_done || (write_done && line_hit);
    assign arr_wdata = refill_done ? i_mem_data : o_mem_data;

    dcache_array #(
        .LINES (LINES),
        .TAG_W (TAG_W)
    ) u_array (
        .clk    (i_clk),
        .rst_n  (i_rst_n),
        .flush  ((state == IDLE) && i_flush),
        .we     (arr_we),
        .widx   (idx),
        .wtag   (req_tag),
        .wdata  (arr_wdata),
        .ridx   (idx),
        .rvalid (line_valid),
        .rtag   (line_tag),
        .rdata  (line_data)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= IDLE;
            o_mem_req  <= 1'b0;
            o_mem_we   <= 1'b0;
            o_mem_addr <= '0;
            o_mem_data <= '0;
            o_hits     <= '0;
            o_misses   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!i_flush && i_req) begin
                        if (i_we) begin
                            state      <= WRITE;
                            o_mem_req  <= 1'b1;
                            o_mem_we   <= 1'b1;
                            o_mem_addr <= {i_addr[WIDTH-1:2], 2'b00};
                            o_mem_data <= i_data;
                        end else if (line_hit) begin
                            if (o_hits != CNT_MAX) o_hits <= o_hits + 16'd1;
                        end else begin
                            state      <= REFILL;
                            o_mem_req  <= 1'b1;
                            o_mem_we   <= 1'b0;
                            o_mem_addr <= {i_addr[WIDTH-1:2], 2'b00};
                            o_mem_data <= '0;
                            if (o_misses != CNT_MAX) o_misses <= o_misses + 16'd1;
                        end
                    end
                end
                REFILL, WRITE: begin
                    if (i_mem_ack) begin
                        state      <= IDLE;
                        o_mem_req  <= 1'b0;
                        o_mem_we   <= 1'b0;
                        o_mem_addr <= '0;
                        o_mem_data <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: directed scenarios followed by random
// loads/stores, compared against a behavioural cache + memory model.
module tb_dcache_ctrl;

    localparam int unsigned WIDTH = 12;
    localparam int unsigned LINES = 16;

    logic             i_clk;
    logic             i_rst_n;
    logic             i_req;
    logic             i_we;
    logic [WIDTH-1:0] i_addr;
    logic [31:0]      i_data;
    logic             i_flush;
    logic [31:0]      o_data;
    logic             o_ready;
    logic             o_mem_req;
    logic             o_mem_we;
    logic [WIDTH-1:0] o_mem_addr;
    logic [31:0]      o_mem_data;
    logic [31:0]      i_mem_data;
    logic             i_mem_ack;
    logic [15:0]      o_hits;
    logic [15:0]      o_misses;

    dcache_ctrl #(
        .WIDTH (WIDTH),
        .LINES (LINES)
    ) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_req      (i_req),
        .i_we       (i_we),
        .i_addr     (i_addr),
        .i_data     (i_data),
        .i_flush    (i_flush),
        .o_data     (o_data),
        .o_ready    (o_ready),
        .o_mem_req  (o_mem_req),
        .o_mem_we   (o_mem_we),
        .o_mem_addr (o_mem_addr),
        .o_mem_data (o_mem_data),
        .i_mem_data (i_mem_data),
        .i_mem_ack  (i_mem_ack),
        .o_hits     (o_hits),
        .o_misses   (o_misses)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Reference model: backing memory by word address, cache lines by index.
    logic [31:0] mem   [1024];
    bit          mvalid[LINES];
    int unsigned mtag  [LINES];
    logic [31:0] mdata [LINES];
    int unsigned exp_hits;
    int unsigned exp_misses;

    int n_checks;
    int n_fail;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < LINES; i++) mvalid[i] = 1'b0;
        exp_hits   = 0;
        exp_misses = 0;
    endtask

    task automatic check_counters(input string nm);
        check({nm, " hits"}, {16'd0, o_hits}, exp_hits);
        check({nm, " misses"}, {16'd0, o_misses}, exp_misses);
    endtask

    // One complete core access; called one time unit after a rising edge.
    task automatic access(input bit we, input logic [11:0] addr, input logic [31:0] wd,
                          input int lat, input string nm);
        int unsigned word = int'(addr) / 4;
        int unsigned idx  = word % LINES;
        int unsigned tag  = word / LINES;
        bit hit = !we && mvalid[idx] && (mtag[idx] == tag);
        logic [31:0] rd;
        i_req  = 1'b1;
        i_we   = we;
        i_addr = addr;
        i_data = wd;
        #1;
        if (hit) begin
            check({nm, " hit ready"}, {31'd0, o_ready}, 32'd1);
            check({nm, " hit data"}, o_data, mdata[idx]);
            check({nm, " hit no mem_req"}, {31'd0, o_mem_req}, 32'd0);
            if (exp_hits < 65535) exp_hits++;
            @(posedge i_clk); #1;
            i_req = 1'b0;
        end else begin
            check({nm, " idle ready"}, {31'd0, o_ready}, 32'd0);
            if (!we && exp_misses < 65535) exp_misses++;
            @(posedge i_clk); #1;
            for (int c = 0; c <= lat; c++) begin
                check({nm, " mem_req"}, {31'd0, o_mem_req}, 32'd1);
                check({nm, " mem_we"}, {31'd0, o_mem_we}, {31'd0, we});
                check({nm, " mem_addr"}, {20'd0, o_mem_addr}, {20'd0, addr & 12'hFFC});
                if (we) check({nm, " mem_data"}, o_mem_data, wd);
                check({nm, " wait ready"}, {31'd0, o_ready}, 32'd0);
                if (c < lat) begin
                    @(posedge i_clk); #1;
                end
            end
            rd = we ? $urandom : mem[word];
            i_mem_ack  = 1'b1;
            i_mem_data = rd;
            #1;
            check({nm, " ack ready"}, {31'd0, o_ready}, 32'd1);
            if (!we) check({nm, " ack data"}, o_data, rd);
            @(posedge i_clk); #1;
            i_mem_ack = 1'b0;
            i_req     = 1'b0;
            if (we) begin
                mem[word] = wd;
                if (mvalid[idx] && mtag[idx] == tag) mdata[idx] = wd;
            end else begin
                mvalid[idx] = 1'b1;
                mtag[idx]   = tag;
                mdata[idx]  = rd;
            end
        end
        check({nm, " back idle"}, {31'd0, o_mem_req}, 32'd0);
        check_counters(nm);
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        i_rst_n    = 1'b0;
        i_req      = 1'b0;
        i_we       = 1'b0;
        i_addr     = '0;
        i_data     = '0;
        i_flush    = 1'b0;
        i_mem_data = '0;
        i_mem_ack  = 1'b0;
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        mem[12'h040 / 4] = 32'hDEADBEEF;
        model_reset();

        // Reset state
        #2;
        check("rst ready", {31'd0, o_ready}, 32'd0);
        check("rst data", o_data, 32'd0);
        check("rst mem_req", {31'd0, o_mem_req}, 32'd0);
        check_counters("rst");
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;

        // Miss then hit on 0x040
        access(1'b0, 12'h040, 32'd0, 3, "ld040 miss");
        check("ld040 misses=1", {16'd0, o_misses}, 32'd1);
        access(1'b0, 12'h040, 32'd0, 0, "ld040 hit");
        check("ld040 hits=1", {16'd0, o_hits}, 32'd1);

        // Store to a cached line, then load it back
        access(1'b1, 12'h040, 32'hCAFEF00D, 2, "st040");
        access(1'b0, 12'h040, 32'd0, 0, "ld040 after st");

        // Store to an uncached line does not allocate
        access(1'b1, 12'h080, 32'h12345678, 1, "st080");
        access(1'b0, 12'h080, 32'd0, 1, "ld080");

        // Same index, different tags evict each other
        access(1'b0, 12'h004, 32'd0, 0, "ld004");
        access(1'b0, 12'h044, 32'd0, 2, "ld044");
        access(1'b0, 12'h004, 32'd0, 1, "ld004 again");

        // Flush wins over a simultaneous request
        access(1'b0, 12'h040, 32'd0, 1, "ld040 pre-flush");
        i_flush = 1'b1;
        i_req   = 1'b1;
        i_we    = 1'b0;
        i_addr  = 12'h040;
        #1;
        check("flush ready", {31'd0, o_ready}, 32'd0);
        @(posedge i_clk); #1;
        i_flush = 1'b0;
        i_req   = 1'b0;
        check("flush stays idle", {31'd0, o_mem_req}, 32'd0);
        check_counters("flush");
        for (int i = 0; i < LINES; i++) mvalid[i] = 1'b0;
        access(1'b0, 12'h040, 32'd0, 0, "ld040 post-flush");

        // Reset in the middle of a refill, followed by a stale ack
        i_req  = 1'b1;
        i_we   = 1'b0;
        i_addr = 12'h0C0;
        @(posedge i_clk); #1;
        check("midrefill mem_req", {31'd0, o_mem_req}, 32'd1);
        i_rst_n = 1'b0;
        #1;
        check("midrst ready", {31'd0, o_ready}, 32'd0);
        check("midrst mem_req", {31'd0, o_mem_req}, 32'd0);
        check("midrst data", o_data, 32'd0);
        model_reset();
        check_counters("midrst");
        #2;
        i_rst_n = 1'b1;
        i_req   = 1'b0;
        @(posedge i_clk); #1;
        i_mem_ack  = 1'b1;
        i_mem_data = 32'hBADC0DE5;
        #1;
        check("late ack ready", {31'd0, o_ready}, 32'd0);
        @(posedge i_clk); #1;
        i_mem_ack = 1'b0;
        check("late ack idle", {31'd0, o_mem_req}, 32'd0);
        check_counters("late ack");
        access(1'b0, 12'h0C0, 32'd0, 1, "ld0C0 after rst");

        // Random traffic over a small address window to mix hits and misses
        for (int n = 0; n < 120; n++) begin
            logic [11:0] a;
            a = 12'($urandom_range(0, 63) * 4) | 12'($urandom_range(0, 3));
            access($urandom_range(0, 3) == 0, a, $urandom, $urandom_range(0, 3), "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
